// File: rtl/alu_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmp_seq
// Brief    : Multi-cycle EQ/NE/LT/LTU compare sequencer; scans operands one
//            SLICE-bit slice per cycle, MSB slice first, through a single
//            narrow comparator. Optional early exit on first differing slice
//            when ALU_CMP_EARLY_EXIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmp_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_v,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [IDXW-1:0] c_IDX_TOP = IDXW'(NSLICE - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [1:0] c_OP_EQ  = 2'b00;
    localparam logic [1:0] c_OP_NE  = 2'b01;
    localparam logic [1:0] c_OP_LT  = 2'b10;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("alu_cmp_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [IDXW-1:0]  r_idx;
    logic             r_diff;
    logic             r_lt;
    logic             r_res;

    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic             w_slice_ne;
    logic             w_sign_case;
    logic             w_diff_nxt;
    logic             w_lt_nxt;
    logic             w_res;
    logic             w_accept;

    assign w_a_slice  = r_a[r_idx*SLICE +: SLICE];
    assign w_b_slice  = r_b[r_idx*SLICE +: SLICE];
    assign w_slice_ne = (w_a_slice != w_b_slice);
    // Signed LT: differing sign bits in the top slice decide the outcome outright.
    assign w_sign_case = (r_idx == c_IDX_TOP) && (r_op == c_OP_LT) &&
                         (r_a[WIDTH-1] ^ r_b[WIDTH-1]);

    always_comb begin
        w_diff_nxt = r_diff;
        w_lt_nxt   = r_lt;
        if (!r_diff && w_slice_ne) begin
            w_diff_nxt = 1'b1;
            w_lt_nxt   = w_sign_case ? r_a[WIDTH-1] : (w_a_slice < w_b_slice);
        end
    end

    always_comb begin
        case (r_op)
            c_OP_EQ: w_res = ~w_diff_nxt;
            c_OP_NE: w_res = w_diff_nxt;
            default: w_res = w_diff_nxt & w_lt_nxt;
        endcase
    end

    assign w_accept = (r_state == c_ST_IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (r_idx == '0) begin
                    w_state_nxt = c_ST_DONE;
                end
`ifdef ALU_CMP_EARLY_EXIT_EN
                else if (!r_diff && w_slice_ne) begin
                    w_state_nxt = c_ST_DONE;
                end
`endif
            end
            c_ST_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= c_OP_EQ;
            r_idx  <= '0;
            r_diff <= 1'b0;
            r_lt   <= 1'b0;
            r_res  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= req_a;
                r_b    <= req_b;
                r_op   <= req_op;
                r_idx  <= c_IDX_TOP;
                r_diff <= 1'b0;
                r_lt   <= 1'b0;
            end else if (r_state == c_ST_BUSY) begin
                r_diff <= w_diff_nxt;
                r_lt   <= w_lt_nxt;
                if (r_idx != '0) begin
                    r_idx <= r_idx - 1'b1;
                end
                if (w_state_nxt == c_ST_DONE) begin
                    r_res <= w_res;
                end
            end
        end
    end

    assign req_ready = (r_state == c_ST_IDLE);
    assign rsp_valid = (r_state == c_ST_DONE);
    assign busy      = (r_state == c_ST_BUSY) || (r_state == c_ST_DONE);
    assign rsp_s     = WIDTH'(r_res);
    assign rsp_v     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmp_seq
// Brief    : Directed self-checking bench for alu_cmp_seq (32-bit, 8-bit slices).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmp_seq;

    localparam int WIDTH  = 32;
    localparam int NSLICE = 4;
`ifdef ALU_CMP_EARLY_EXIT_EN
    localparam bit c_EARLY = 1'b1;
`else
    localparam bit c_EARLY = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_s;
    logic             rsp_v;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_cmp_seq #(.WIDTH(WIDTH), .SLICE(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_v     (rsp_v),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // k = index of the most significant differing slice, -1 when equal.
    function automatic int exp_lat(input int k);
        return (c_EARLY && k >= 0) ? (NSLICE - k) : NSLICE;
    endfunction

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!req_ready && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Issue one op and count edges from accept until rsp_valid.
    task automatic issue(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
        wait_ready(tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = a ^ 32'h5A5A_5A5A;
        req_op    = ~op;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic exp_s, input int k);
        int lat;
        logic [31:0] exp_word;
        exp_word = {31'd0, exp_s};
        rsp_ready = 1'b1;
        issue(tag, op, a, b, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat(k)));
        check({tag, "_s"}, rsp_s, exp_word);
        check({tag, "_v"}, 32'(rsp_v), 32'd0);
        check({tag, "_rdy_in_done"}, 32'(req_ready), 32'd0);
        step();
        check({tag, "_drain"}, {30'd0, rsp_valid, req_ready}, 32'd1);
        check({tag, "_s_hold"}, rsp_s, exp_word);
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = 2'b00;
        rsp_ready = 1'b1;
        step();
        step();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_s",     rsp_s, 32'd0);
        check("rst_v",     32'(rsp_v), 32'd0);
        reset = 1'b0;
        step();
        check("rst_ready", 32'(req_ready), 32'd1);

        //      tag          op     A              B              S     k
        run_op("eq_same",   2'b00, 32'h1234_5678, 32'h1234_5678, 1'b1, -1);
        run_op("lt_neg",    2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1,  3);
        run_op("ltu_big",   2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0,  3);
        run_op("ne_s0",     2'b01, 32'h0000_0001, 32'h0000_0000, 1'b1,  0);
        run_op("eq_msb",    2'b00, 32'h8000_0000, 32'h0000_0000, 1'b0,  3);
        run_op("lt_small",  2'b10, 32'h0000_0005, 32'h0000_0009, 1'b1,  0);
        run_op("ltu_sign",  2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0,  3);
        run_op("lt_sign",   2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1,  3);
        run_op("lt_negneg", 2'b10, 32'hFFFF_FF00, 32'hFFFF_FF01, 1'b1,  0);
        run_op("ltu_s2",    2'b11, 32'h0001_0000, 32'h0002_0000, 1'b1,  2);
        run_op("lt_first",  2'b10, 32'h0100_0000, 32'h00FF_FFFF, 1'b0,  3);
        run_op("ltu_first", 2'b11, 32'h00FF_0000, 32'h0100_0000, 1'b1,  3);
        run_op("ne_same",   2'b01, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, -1);
        run_op("lt_same",   2'b10, 32'h8765_4321, 32'h8765_4321, 1'b0, -1);

        // Backpressure: result must hold and new requests must be ignored.
        rsp_ready = 1'b0;
        issue("bp", 2'b00, 32'h0000_0005, 32'h0000_0005, lat);
        check("bp_lat", 32'(lat), 32'(NSLICE));
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_op    = 2'b01;
            req_a     = 32'h1;
            req_b     = 32'h2;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_s",     rsp_s, 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_busy",  32'(busy), 32'd1);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("bp_still_valid", 32'(rsp_valid), 32'd1);
        step();
        check("bp_release", {29'd0, rsp_valid, busy, req_ready}, 32'd1);
        check("bp_s_keep", rsp_s, 32'd1);

        // Reset during the second BUSY cycle drops the op.
        wait_ready("rm");
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'h0000_0001;
        req_b     = 32'h0000_0001;
        step();
        req_valid = 1'b0;
        check("rm_busy1", 32'(busy), 32'd1);
        step();
        check("rm_busy2", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rm_valid", 32'(rsp_valid), 32'd0);
        check("rm_busy",  32'(busy), 32'd0);
        check("rm_ready", 32'(req_ready), 32'd1);
        check("rm_s",     rsp_s, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (rsp_valid || busy) seen++;
            end
            check("rm_no_rsp", 32'(seen), 32'd0);
        end

        run_op("post_rst", 2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
